// File: rtl/rs_enc_ctrl.sv
// Control path for a systematic Reed-Solomon encoder: sequences message bytes into an external
// LFSR stage chain, then drains the chain's tail register as parity behind a one-cycle output register.
module rs_enc_ctrl #(
    parameter int K    = 239,
    parameter int NPAR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] r_tail,
    output logic [7:0] enc_mr,
    output logic       enc_en,
    output logic       enc_clr,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       err
);
    typedef enum logic [1:0] {S_IDLE, S_MSG, S_FLUSH, S_PAR} state_e;

    state_e     state_q, state_d;
    logic [7:0] msg_cnt_q, msg_cnt_d;
    logic [7:0] par_cnt_q, par_cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_sop_q, out_sop_d;
    logic       out_eop_q, out_eop_d;
    logic       err_q, err_d;
    logic       start;

    always_comb begin
        state_d     = state_q;
        msg_cnt_d   = msg_cnt_q;
        par_cnt_d   = par_cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        enc_en      = 1'b0;
        enc_mr      = 8'h00;
        enc_clr     = 1'b0;
        start       = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_sop) start = 1'b1;
                    else        err_d = 1'b1;
                end
            end
            S_MSG: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_sop) begin
                        start   = 1'b1;
                        err_d   = 1'b1;
                        enc_clr = 1'b1;
                    end else begin
                        enc_en      = 1'b1;
                        enc_mr      = in_data ^ r_tail;
                        msg_cnt_d   = msg_cnt_q + 8'd1;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        if (msg_cnt_q == 8'(K - 1)) state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                par_cnt_d = 8'd0;
                state_d   = S_PAR;
            end
            S_PAR: begin
                enc_en      = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = r_tail;
                par_cnt_d   = par_cnt_q + 8'd1;
                if (par_cnt_q == 8'(NPAR - 1)) begin
                    out_eop_d = 1'b1;
                    enc_clr   = 1'b1;
                    par_cnt_d = 8'd0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // On an abort the chain is cleared this same cycle, so the feedback sees an empty tail
        if (start) begin
            enc_en      = 1'b1;
            enc_mr      = enc_clr ? in_data : (in_data ^ r_tail);
            msg_cnt_d   = 8'd1;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_sop_d   = 1'b1;
            state_d     = (K == 1) ? S_FLUSH : S_MSG;
        end
        if (!rst) begin
            in_ready = 1'b0;
            enc_en   = 1'b0;
            enc_mr   = 8'h00;
            enc_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            msg_cnt_q   <= 8'd0;
            par_cnt_q   <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_cnt_q   <= msg_cnt_d;
            par_cnt_q   <= par_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign err       = err_q;
endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Scoreboard bench for rs_enc_ctrl: an LFSR stage-chain model supplies r_tail, and expected
// codewords come from polynomial long division by the RS(255,239) generator over GF(2^8)/0x11D.
module tb_rs_enc_ctrl;
    localparam int K    = 239;
    localparam int NPAR = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0, in_sop = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] r_tail, enc_mr;
    logic       enc_en, enc_clr, out_valid, out_sop, out_eop, err;
    logic [7:0] out_data;

    rs_enc_ctrl #(.K(K), .NPAR(NPAR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
        .in_ready(in_ready), .r_tail(r_tail), .enc_mr(enc_mr), .enc_en(enc_en),
        .enc_clr(enc_clr), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t      exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         err_cnt = 0;
    logic [7:0] gen [0:NPAR];
    logic [7:0] chain [0:NPAR-1];
    logic [7:0] msg [0:254];
    logic [7:0] par [0:NPAR-1];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    // Environment: the encoder stage chain the controller drives (clear+advance loads from zero)
    initial for (int i = 0; i < NPAR; i++) chain[i] = 8'h00;
    always @(posedge clk) begin
        if (enc_en || enc_clr) begin
            chain[0] <= enc_en ? gmul(enc_mr, gen[0]) : 8'h00;
            for (int i = 1; i < NPAR; i++)
                chain[i] <= (enc_en ? gmul(enc_mr, gen[i]) : 8'h00) ^ (enc_clr ? 8'h00 : chain[i-1]);
        end
    end
    assign r_tail = chain[NPAR-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic build_gen();
        logic [7:0] alpha = 8'h01;
        for (int j = 0; j <= NPAR; j++) gen[j] = (j == 0) ? 8'h01 : 8'h00;
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], alpha);
            gen[0] = gmul(gen[0], alpha);
            alpha = gmul(alpha, 8'h02);
        end
    endtask

    // Remainder of m(x)*x^NPAR divided by g(x); arr[0] is the highest-order coefficient
    task automatic ref_parity();
        logic [7:0] arr [0:K+NPAR-1];
        logic [7:0] c;
        for (int i = 0; i < K + NPAR; i++) arr[i] = (i < K) ? msg[i] : 8'h00;
        for (int i = 0; i < K; i++) begin
            c = arr[i];
            for (int j = 1; j <= NPAR; j++) arr[i+j] = arr[i+j] ^ gmul(c, gen[NPAR-j]);
        end
        for (int p = 0; p < NPAR; p++) par[p] = arr[K+p];
    endtask

    task automatic push(input logic [7:0] d, input logic sop, input logic eop);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back, 1: one idle cycle between beats, 2: random gaps of 0..2 cycles
    task automatic drive_msg(input int mode, input int nbytes, input bit with_parity);
        int gaps;
        for (int i = 0; i < nbytes; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_data  = msg[i];
            push(msg[i], i == 0, 1'b0);
            tick();
            gaps = (i == nbytes - 1) ? 0 : (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_sop   = 1'b0;
                #1;
                check("enc_en_stall", enc_en, 1'b0);
                check("enc_mr_stall", enc_mr, 8'h00);
                tick();
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        if (with_parity) begin
            ref_parity();
            for (int p = 0; p < NPAR; p++) push(par[p], 1'b0, p == NPAR - 1);
        end
    endtask

    task automatic wait_ready(output int busy);
        busy = 0;
        while (!in_ready && busy < 100) begin
            busy++;
            tick();
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            tick();
        end
        tick();
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops one expected beat per valid output byte
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (err) err_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", {out_sop, out_eop, out_data}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_sop", out_sop, e.sop);
                    check("out_eop", out_eop, e.eop);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int e0;
        build_gen();
        rst = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_enc_en", enc_en, 1'b0);
        check("rst_enc_mr", enc_mr, 8'h00);
        check("rst_enc_clr", enc_clr, 1'b1);
        check("rst_out", {out_valid, out_sop, out_eop, err, out_data}, 0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        tick();

        // Back-to-back ramp 0x00..0xEE
        for (int i = 0; i < K; i++) msg[i] = 8'(i);
        drive_msg(0, K, 1'b1);
        wait_ready(busy);
        check("busy_cycles_b2b", busy, 17);
        drain("drain_b2b");

        // All-zero message gives all-zero parity
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        drive_msg(0, K, 1'b1);
        check("zero_parity", par[0] | par[NPAR-1], 8'h00);
        wait_ready(busy);
        drain("drain_zero");

        // Same ramp with in_valid toggling
        for (int i = 0; i < K; i++) msg[i] = 8'(i);
        drive_msg(1, K, 1'b1);
        wait_ready(busy);
        check("busy_cycles_toggle", busy, 17);
        drain("drain_toggle");

        // Abort at message byte 100, followed by a full word
        e0 = err_cnt;
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        drive_msg(0, 100, 1'b0);
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        drive_msg(0, K, 1'b1);
        wait_ready(busy);
        drain("drain_abort");
        check("abort_err_pulses", err_cnt - e0, 1);

        // Reset during parity at par_cnt=5: only parity bytes 0..4 ever appear
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        drive_msg(0, K, 1'b0);
        ref_parity();
        for (int p = 0; p < 5; p++) push(par[p], 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b0;
        #1;
        check("midrst_enc_clr", enc_clr, 1'b1);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_enc_en", enc_en, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_rel_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_drained", exp_q.size(), 0);
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        drive_msg(2, K, 1'b1);
        wait_ready(busy);
        drain("drain_after_rst");

        // Stray beat in IDLE without sop is dropped
        e0 = err_cnt;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_data  = 8'h5A;
        #1;
        check("drop_enc_en", enc_en, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("drop_err", err_cnt - e0, 1);
        check("drop_out_valid", out_valid, 1'b0);
        check("drop_in_ready", in_ready, 1'b1);

        // Random data with random stalls
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
            drive_msg(2, K, 1'b1);
            wait_ready(busy);
            check("busy_cycles_rand", busy, 17);
            drain("drain_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
